// File: rtl/scalar_recoder_pkg.sv
// rtl/scalar_recoder_pkg.sv - shared types and helpers for the scalar window recoder
//
// Package recoder_pkg:
//   digit_t    : signed digit at the default window width (WIN_W=4 -> 5 bits)
//   state_e    : recoder FSM states
//   win_count  : number of WIN_W-bit windows covering a SCALAR_W-bit scalar
package recoder_pkg;

    localparam int DEF_WIN_W = 4;
    localparam int DEF_DIG_W = DEF_WIN_W + 1;

    typedef logic signed [DEF_DIG_W-1:0] digit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int win_count(input int scalar_w, input int win_w);
        return (scalar_w + win_w - 1) / win_w;
    endfunction

endpackage

// File: rtl/scalar_recoder_window_recode.sv
// rtl/scalar_recoder_window_recode.sv - combinational recode of one window digit
//
// Ports:
//   nib         in   WIN_W   raw window bits
//   carry_in    in   1       carry from the previous (lower) window
//   signed_mode in   1       1 = signed-digit recoding, 0 = plain unsigned window
//   digit       out  WIN_W+1 signed output digit
//   carry_out   out  1       carry into the next (higher) window
module window_recode #(
    parameter  int WIN_W = 4,
    localparam int DIG_W = WIN_W + 1
) (
    input  logic [WIN_W-1:0]        nib,
    input  logic                    carry_in,
    input  logic                    signed_mode,
    output logic signed [DIG_W-1:0] digit,
    output logic                    carry_out
);

    localparam logic [DIG_W-1:0] HALF = DIG_W'(1) << (WIN_W - 1);
    localparam logic [DIG_W-1:0] FULL = DIG_W'(1) << WIN_W;

    logic [DIG_W-1:0] t;

    always_comb begin
        // One extra bit so nib=all-ones plus carry does not wrap.
        t         = {1'b0, nib} + {{WIN_W{1'b0}}, carry_in};
        digit     = t;
        carry_out = 1'b0;
        // Upper half of the window range folds to a negative digit and
        // pushes one unit of 2^WIN_W into the next window.
        if (signed_mode && (t >= HALF)) begin
            digit     = t - FULL;
            carry_out = 1'b1;
        end
    end

endmodule

// File: rtl/scalar_recoder.sv
// rtl/scalar_recoder.sv - streams a scalar LSB-first as unsigned or signed window digits
//
// Optional feature macro: SCALAR_RECODER_DIGIT_IDX_EN adds out_idx (current digit index).
//
// Parameters: SCALAR_W scalar width, WIN_W window width (2..8).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       scalar load handshake
//   in_scalar               scalar, little-endian bit order
//   in_signed               mode sampled at load (1 = signed recoding)
//   out_valid/out_ready     digit handshake
//   out_digit               current signed digit (WIN_W+1 bits)
//   out_last                final digit of the scalar
//   out_idx                 (optional) digit index, valid with out_valid
module scalar_recoder
    import recoder_pkg::*;
#(
    parameter  int SCALAR_W = 256,
    parameter  int WIN_W    = 4,
    localparam int NUM_WIN  = win_count(SCALAR_W, WIN_W),
    localparam int DIG_W    = WIN_W + 1,
    localparam int CNT_W    = $clog2(NUM_WIN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCALAR_W-1:0]     in_scalar,
    input  logic                    in_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DIG_W-1:0] out_digit,
    output logic                    out_last
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
    ,
    output logic [CNT_W-1:0]        out_idx
`endif
);

    localparam int SH_W = NUM_WIN * WIN_W;

    state_e              state_q, state_d;
    logic [SH_W-1:0]     shreg_q, shreg_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mode_q, mode_d;
    logic                out_valid_q, out_valid_d;

    logic signed [DIG_W-1:0] digit_raw;
    logic                    carry_nxt;
    logic [CNT_W-1:0]        last_idx;
    logic                    is_last;
    logic                    out_fire;

    window_recode #(.WIN_W(WIN_W)) u_window_recode (
        .nib         (shreg_q[WIN_W-1:0]),
        .carry_in    (carry_q),
        .signed_mode (mode_q),
        .digit       (digit_raw),
        .carry_out   (carry_nxt)
    );

    // Signed mode emits one extra digit holding the final carry; by then the
    // shift register is empty, so the recoder naturally yields digit = carry.
    assign last_idx = mode_q ? CNT_W'(NUM_WIN) : CNT_W'(NUM_WIN - 1);
    assign is_last  = (count_q == last_idx);
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        carry_d     = carry_q;
        count_d     = count_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = RUN;
                    shreg_d     = SH_W'(in_scalar);
                    mode_d      = in_signed;
                    carry_d     = 1'b0;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                end
            end
            RUN: begin
                if (out_fire) begin
                    shreg_d = shreg_q >> WIN_W;
                    carry_d = carry_nxt;
                    count_d = count_q + CNT_W'(1);
                    if (is_last) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_digit = out_valid_q ? digit_raw : '0;
    assign out_last  = out_valid_q && is_last;

`ifdef SCALAR_RECODER_DIGIT_IDX_EN
    assign out_idx = count_q;
`endif

endmodule

// File: tb/tb_scalar_recoder.sv
// tb/tb_scalar_recoder.sv - directed bench for scalar_recoder
module tb_scalar_recoder;
    import recoder_pkg::*;

    localparam int SW = 256;
    localparam int WW = 4;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_scalar = '0;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    digit_t        out_digit;
    logic          out_last;
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
    logic [CW-1:0] out_idx;
`endif

    scalar_recoder #(.SCALAR_W(SW), .WIN_W(WW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scalar (in_scalar),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last)
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    // Second instance with a partial top window (254 = 63*4 + 2).
    logic          p_in_valid = 1'b0;
    logic          p_in_ready;
    logic [253:0]  p_in_scalar = '0;
    logic          p_in_signed = 1'b0;
    logic          p_out_valid;
    logic          p_out_ready = 1'b1;
    digit_t        p_out_digit;
    logic          p_out_last;
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
    logic [CW-1:0] p_out_idx;
`endif

    scalar_recoder #(.SCALAR_W(254), .WIN_W(WW)) dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_scalar (p_in_scalar),
        .in_signed (p_in_signed),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_digit (p_out_digit),
        .out_last  (p_out_last)
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
        ,
        .out_idx   (p_out_idx)
`endif
    );

    typedef struct {
        logic [SW-1:0] scalar;
        logic          sgn;
        int            exp_n;
        int            d0;
        int            d1;
        int            d2;
        int            dl;
    } vec_t;

    vec_t   vecs [7];
    digit_t dig [70];
    int     got_n, got_nlast, got_last_idx, got_stab, got_rdy_err, got_idx_err;
    int     n_cmp = 0;
    int     n_fail = 0;

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [263:0] recon();
        logic signed [263:0] acc;
        logic signed [263:0] term;
        acc = '0;
        for (int i = 0; i < got_n && i < 70; i++) begin
            term = dig[i];
            term = term <<< (WW * i);
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Entered and left at a falling edge.
    task automatic load(input logic [SW-1:0] s, input logic sg);
        in_scalar = s;
        in_signed = sg;
        in_valid  = 1'b1;
        chk("load_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("load_latency_out_valid", out_valid, 1);
    endtask

    task automatic drain(input bit stall);
        bit     done = 1'b0;
        bit     have_prev = 1'b0;
        digit_t prev = '0;
        int     cyc = 0;
        got_n = 0; got_nlast = 0; got_last_idx = -1;
        got_stab = 0; got_rdy_err = 0; got_idx_err = 0;
        while (!done && cyc < 400) begin
            out_ready = stall ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (out_valid) begin
                if (in_ready) got_rdy_err++;
                if (have_prev && out_digit !== prev) got_stab++;
                if (out_ready) begin
`ifdef SCALAR_RECODER_DIGIT_IDX_EN
                    if (out_idx !== CW'(got_n)) got_idx_err++;
`endif
                    if (got_n < 70) dig[got_n] = out_digit;
                    if (out_last) begin
                        got_nlast++;
                        got_last_idx = got_n;
                        done = 1'b1;
                    end
                    got_n++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev = out_digit;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        chk("drain_done", done, 1);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("in_ready_low_in_run", got_rdy_err, 0);
        chk("digit_stable_in_stall", got_stab, 0);
        chk("digit_index", got_idx_err, 0);
        chk("single_last", got_nlast, 1);
        chk("last_position", got_last_idx, got_n - 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [SW-1:0] s;
        int            p_n, p_nlast, p_bad, p_cyc;
        digit_t        p_last_dig;

        vecs[0] = '{256'hF1, 1'b0, 64, 1, 15, 0, 0};
        vecs[1] = '{256'hF8, 1'b1, 65, -8, 0, 1, 0};
        vecs[2] = '{{SW{1'b1}}, 1'b1, 65, -1, 0, 0, 1};
        vecs[3] = '{{SW{1'b1}}, 1'b0, 64, 15, 15, 15, 15};
        vecs[4] = '{256'h7, 1'b1, 65, 7, 0, 0, 0};
        vecs[5] = '{256'h321, 1'b0, 64, 1, 2, 3, 0};
        vecs[6] = '{256'h9C, 1'b1, 65, -4, -6, 1, 0};

        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_digit", out_digit, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].scalar, vecs[i].sgn);
            drain(1'b0);
            chk($sformatf("v%0d_count", i), got_n, vecs[i].exp_n);
            chk($sformatf("v%0d_d0", i), dig[0], vecs[i].d0);
            chk($sformatf("v%0d_d1", i), dig[1], vecs[i].d1);
            chk($sformatf("v%0d_d2", i), dig[2], vecs[i].d2);
            chk($sformatf("v%0d_dlast", i), dig[(got_n > 0 && got_n <= 70) ? got_n - 1 : 0], vecs[i].dl);
            chk($sformatf("v%0d_recon", i), recon(), {8'd0, vecs[i].scalar});
        end

        // Backpressure on a random signed scalar.
        for (int w = 0; w < SW / 32; w++) s[w*32 +: 32] = $urandom;
        load(s, 1'b1);
        drain(1'b1);
        chk("bp_count", got_n, 65);
        chk("bp_recon", recon(), {8'd0, s});

        // Held in_valid with a different scalar during RUN.
        in_scalar = 256'h5;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_scalar = 256'hA;
        chk("hold_out_valid", out_valid, 1);
        drain(1'b0);
        chk("hold_first_count", got_n, 64);
        chk("hold_first_d0", dig[0], 5);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_second_accept", out_valid, 1);
        drain(1'b0);
        chk("hold_second_d0", dig[0], 10);
        chk("hold_second_recon", recon(), 264'hA);

        // Partial top window on the 254-bit instance.
        p_in_scalar = {254{1'b1}};
        p_in_signed = 1'b0;
        p_in_valid  = 1'b1;
        chk("p_in_ready", p_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        p_in_valid = 1'b0;
        p_n = 0; p_nlast = 0; p_bad = 0; p_cyc = 0; p_last_dig = '0;
        while (p_nlast == 0 && p_cyc < 200) begin
            if (p_out_valid) begin
                if (p_out_last) begin
                    p_nlast++;
                    p_last_dig = p_out_digit;
                end else if (p_out_digit !== 5'sd15) begin
                    p_bad++;
                end
                p_n++;
            end
            @(posedge clk);
            @(negedge clk);
            p_cyc++;
        end
        chk("p_count", p_n, 64);
        chk("p_last_seen", p_nlast, 1);
        chk("p_top_digit", p_last_dig, 3);
        chk("p_lower_digits", p_bad, 0);
        chk("p_idle", p_in_ready, 1);

        // Reset mid-stream after 10 digits.
        for (int w = 0; w < SW / 32; w++) s[w*32 +: 32] = $urandom;
        load(s, 1'b0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        load(256'h1, 1'b0);
        drain(1'b0);
        chk("post_reset_count", got_n, 64);
        chk("post_reset_d0", dig[0], 1);
        chk("post_reset_d1", dig[1], 0);
        chk("post_reset_recon", recon(), 264'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/scalar_recoder.md
Name: scalar_recoder

Overview:
- Sequential, parametrised successor to the combinational nibble splitter used ahead of the Ed25519 fixed-base scalar multiplier.
- Accepts a SCALAR_W-bit scalar through a valid/ready load port and streams it LSB-first as WIN_W-bit window digits, one per cycle, through a valid/ready/last port.
- Two runtime modes: unsigned windows, or signed-digit recoding into [-2^(WIN_W-1), 2^(WIN_W-1)-1] with carry propagation, as required by the signed precomputed-table lookup.

Parameters:
- SCALAR_W, 256, scalar width in bits.
- WIN_W, 4, window width in bits; legal range 2..8.
- NUM_WIN, ceil(SCALAR_W/WIN_W), localparam; window count. A partial top window is zero-extended.
- DIG_W, WIN_W+1, localparam; signed output digit width.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, scalar load request.
- in_ready, output, 1, block can accept a scalar.
- in_scalar, input, SCALAR_W, scalar, little-endian bit order.
- in_signed, input, 1, mode select sampled at load; 1 = signed recoding, 0 = unsigned.
- out_valid, output, 1, out_digit is valid.
- out_ready, input, 1, consumer accepts the digit.
- out_digit, output, DIG_W (signed), current digit.
- out_last, output, 1, final digit of the scalar.

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE, in_ready=1, out_valid=0, out_last=0, out_digit=0, carry=0, count=0, shift register cleared.
- FSM: IDLE -> RUN on (in_valid && in_ready). RUN -> IDLE on the out handshake with out_last=1.
- in_ready = (state==IDLE). in_valid is ignored in RUN; a held scalar waits.
- Load: latch in_scalar into the shift register (zero-padded to NUM_WIN*WIN_W), latch mode, clear carry and count. out_valid=1 on the cycle after acceptance, so latency is 1.
- Per-digit computation:
  - nib = shreg[WIN_W-1:0].
  - Unsigned mode: digit = nib (zero-extended to DIG_W).
  - Signed mode: t = nib + carry, evaluated at WIN_W+1 bits. If t >= 2^(WIN_W-1), then digit = t - 2^WIN_W and next carry = 1. Otherwise digit = t and next carry = 0.
- out_digit is combinational from the registers and stays stable while out_valid && !out_ready.
- On the out handshake: shift shreg right by WIN_W, update carry, increment count.
- Digit count per scalar:
  - Unsigned: NUM_WIN digits; out_last on count == NUM_WIN-1.
  - Signed: NUM_WIN+1 digits. The final digit is the carry (0 or 1); out_last on count == NUM_WIN.
- Throughput: one digit per cycle with out_ready held high. IDLE lasts at least one cycle between scalars, so a new load is never accepted in the same cycle as the last handshake.
- Stall: out_ready=0 freezes all state indefinitely.
- Reset mid-stream: the stream is abandoned immediately and no further digits are emitted. After release, in_ready=1 in the first cycle.
- Invariant: signed mode reconstructs the scalar exactly: sum of digit_i * 2^(WIN_W*i) == scalar.

Optional Feature:
- Macro: SCALAR_RECODER_DIGIT_IDX_EN.
- When defined: adds output port out_idx, width $clog2(NUM_WIN+1), equal to count. It is valid with out_valid, reset to 0, and used by the table-address generator.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package recoder_pkg holds:
  - digit typedef: logic signed [DIG_W-1:0];
  - state enum {IDLE, RUN};
  - function win_count(SCALAR_W, WIN_W).
- One natural sub-module, window_recode: purely combinational (nib, carry_in, signed_mode) -> (digit, carry_out). It is reused by the future parallel recoder.

Test Plan (WIN_W=4, SCALAR_W=256 unless noted):
- Unsigned load of 0x...00F1 with out_ready=1 -> digits 1,15,0,...,0. 64 digits, out_last only on the 64th, then in_ready=1.
- Signed load with low byte 0xF8, rest 0 -> digits -8,0,1,0,...,0. 65 digits total; last digit 0 with out_last=1.
- Signed load of all-ones -> digits -1,0,0,...,0, then final carry digit 1 with out_last. The weighted sum equals 2^256-1.
- Backpressure: out_ready toggling 1/0 on a random signed scalar -> no dropped or duplicated digits, out_digit stable during stalls, and the reconstruction equals the scalar.
- Reset asserted after 10 digits -> out_valid=0 asynchronously, in_ready=1 after release. A fresh unsigned 0x1 load yields 1,0,...,0 and count restarts at 0.
- in_valid held high during RUN with a different scalar -> the second scalar is not accepted until IDLE. With SCALAR_W=254, WIN_W=4, a partial top window is zero-padded and 64 digits are emitted.
